// File: rtl/led_sequencer.sv
// led_sequencer: run-gated, prescaled LED pattern generator with rotate, bounce, binary and breathe modes
module led_sequencer #(
  parameter int NLEDS     = 8,
  parameter int LOG2DELAY = 20,
  parameter int PWM_BITS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             run,
  output logic [NLEDS-1:0] led,
  output logic             tick
);
  localparam int PW = $clog2(NLEDS);
  localparam logic [1:0] ROTATE  = 2'd0;
  localparam logic [1:0] BOUNCE  = 2'd1;
  localparam logic [1:0] BINARY  = 2'd2;
  localparam logic [1:0] BREATHE = 2'd3;
  localparam logic [PW-1:0] POS_LAST = PW'(NLEDS - 1);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [PWM_BITS-1:0] BR_LAST = '1;
  localparam logic [PWM_BITS-1:0] BR_ONE  = PWM_BITS'(1);

  logic [LOG2DELAY-1:0] presc_q, presc_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic                 dir_q, dir_d;
  logic [NLEDS-1:0]     bcnt_q, bcnt_d;
  logic [PWM_BITS-1:0]  bright_q, bright_d;
  logic                 bdir_q, bdir_d;
  logic [PWM_BITS-1:0]  pwm_q, pwm_d;
  logic [1:0]           mode_q, mode_d;
  logic [NLEDS-1:0]     led_q, led_d;
  logic                 tick_q, tick_d;
  logic                 mode_chg, step;

  assign mode_chg = mode != mode_q;
  assign step     = run && (&presc_q);
  assign pwm_d    = pwm_q + PWM_BITS'(1);
  assign led      = led_q;
  assign tick     = tick_q;

  // Next state: a mode change restarts everything and swallows a coincident step; otherwise only the active mode's state advances on a step
  always_comb begin
    presc_d  = presc_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    bcnt_d   = bcnt_q;
    bright_d = bright_q;
    bdir_d   = bdir_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    if (mode_chg) begin
      mode_d   = mode;
      presc_d  = '0;
      pos_d    = '0;
      dir_d    = 1'b0;
      bcnt_d   = '0;
      bright_d = '0;
      bdir_d   = 1'b0;
    end else begin
      presc_d = run ? presc_q + LOG2DELAY'(1) : presc_q;
      tick_d  = step;
      if (step) begin
        case (mode_q)
          ROTATE: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
          BOUNCE: begin
            pos_d = !dir_q ? ((pos_q == POS_LAST) ? POS_LAST - POS_ONE : pos_q + POS_ONE)
                           : ((pos_q == '0) ? POS_ONE : pos_q - POS_ONE);
            dir_d = !dir_q ? (pos_q == POS_LAST) : (pos_q != '0);
          end
          BINARY: bcnt_d = bcnt_q + NLEDS'(1);
          default: begin
            bright_d = !bdir_q ? ((bright_q == BR_LAST) ? BR_LAST - BR_ONE : bright_q + BR_ONE)
                               : ((bright_q == '0) ? BR_ONE : bright_q - BR_ONE);
            bdir_d   = !bdir_q ? (bright_q == BR_LAST) : (bright_q != '0);
          end
        endcase
      end
    end
  end

  // Pattern is taken from next-state values so led changes on the same edge that raises tick
  always_comb begin
    led_d = (mode_d == BINARY)  ? bcnt_d :
            (mode_d == BREATHE) ? {NLEDS{pwm_d < bright_d}} :
                                  NLEDS'(1) << pos_d;
  end

  // State and registered outputs; reset clears everything without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      bcnt_q   <= '0;
      bright_q <= '0;
      bdir_q   <= 1'b0;
      pwm_q    <= '0;
      mode_q   <= '0;
      led_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      bcnt_q   <= bcnt_d;
      bright_q <= bright_d;
      bdir_q   <= bdir_d;
      pwm_q    <= pwm_d;
      mode_q   <= mode_d;
      led_q    <= led_d;
      tick_q   <= tick_d;
    end
  end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed plus randomized stimulus against a step-count reference model
module tb_led_sequencer;
  localparam int N = 8;
  localparam int L = 2;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [N-1:0] led;
  logic         tick;

  led_sequencer #(.NLEDS(N), .LOG2DELAY(L), .PWM_BITS(P)) dut (
    .clk(clk), .rst(rst), .mode(mode), .run(run), .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_presc, m_steps, m_pwm;
  logic [1:0] m_mode;
  logic m_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Pattern derived from the number of steps taken since the mode (re)started
  function automatic logic [N-1:0] pattern();
    int p;
    case (m_mode)
      2'd0: return N'(1 << (m_steps % N));
      2'd1: begin
        p = m_steps % (2*N - 2);
        return N'(1 << (p < N ? p : 2*N - 2 - p));
      end
      2'd2: return N'(m_steps % (1 << N));
      default: begin
        p = m_steps % 6;
        return (m_pwm < (p <= 3 ? p : 6 - p)) ? {N{1'b1}} : {N{1'b0}};
      end
    endcase
  endfunction

  task automatic model_reset();
    m_presc = 0; m_steps = 0; m_pwm = 0; m_mode = 2'd0; m_tick = 1'b0;
  endtask

  task automatic cyc(input logic r, input logic [1:0] md);
    run = r;
    mode = md;
    @(posedge clk);
    m_pwm = (m_pwm + 1) % (1 << P);
    if (md != m_mode) begin
      m_mode = md; m_presc = 0; m_steps = 0; m_tick = 1'b0;
    end else begin
      m_tick = r && (m_presc == (1 << L) - 1);
      if (r) m_presc = (m_presc + 1) % (1 << L);
      if (m_tick) m_steps++;
    end
    #1;
    check("led", led, pattern());
    check("tick", tick, m_tick);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_led", led, 0);
    check("reset_tick", tick, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0);
    check("first_led", led, 8'h01);
    repeat (40) cyc(1, 0);
    repeat (14*4 + 8) cyc(1, 1);
    repeat (258*4) cyc(1, 2);
    repeat (6*4*2) cyc(1, 3);
    // pause one clock into a period
    cyc(1, 0);
    cyc(1, 0);
    repeat (10) cyc(0, 0);
    cyc(1, 0);
    cyc(1, 0);
    cyc(1, 0);
    check("pause_resume_tick", tick, 1);
    // mode switch exactly when the prescaler is full
    cyc(1, 1);
    repeat (3) cyc(1, 1);
    cyc(1, 0);
    check("switch_no_tick", tick, 0);
    check("switch_led", led, 8'h01);
    repeat (3) cyc(1, 0);
    cyc(1, 0);
    check("switch_first_step", tick, 1);
    // async reset while showing 0x10
    cyc(1, 2);
    cyc(1, 0);
    repeat (16) cyc(1, 0);
    check("pre_reset_led", led, 8'h10);
    #2 rst = 1'b1;
    #1;
    check("async_led", led, 0);
    check("async_tick", tick, 0);
    #1 rst = 1'b0;
    model_reset();
    cyc(1, 0);
    check("post_reset_led", led, 8'h01);
    // randomized run and mode
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 3)) : m_mode);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern generator for the iCE40 example boards; successor to the fixed 8-LED one-hot chaser. It drives NLEDS outputs from one clock through a run-gated prescaler and supports four runtime-selectable modes: rotate, bounce, binary count and PWM breathing. It sits directly between the board clock pin and the LED pins in the top level, with mode and run driven from switches or constants.

## Interface
- NLEDS, 8: number of LED outputs; must be ≥ 2.
- LOG2DELAY, 20: prescaler width. One pattern step occurs every 2^LOG2DELAY clocks while running.
- PWM_BITS, 4: breathing brightness and PWM counter width.

- clk  in  1  board clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mode  in  2  0 = rotate, 1 = bounce, 2 = binary, 3 = breathe.
- run  in  1  1 = advance; 0 = freeze the prescaler and pattern.
- led  out  NLEDS  LED drive, active-high, registered.
- tick  out  1  one-cycle pulse on each pattern step, registered.

## Operation
- State registers:
  - presc[LOG2DELAY]
  - pos[$clog2(NLEDS)]
  - dir (0 = up)
  - bcnt[NLEDS]
  - bright[PWM_BITS]
  - bdir
  - pwm[PWM_BITS]
  - mode_q[2]
- Reset: all registers clear to 0, including led and tick. This is asynchronous and takes effect without a clock edge.
- pwm increments every clock and wraps. It is unaffected by run.
- presc increments when run=1 and holds when run=0.
- Step event: run=1 and presc = all-ones. presc wraps to 0 on that edge.
- Mode change: mode ≠ mode_q.
  - On that edge: mode_q ← mode; presc, pos, dir, bcnt, bright and bdir clear to 0; tick ← 0.
  - A mode change has priority over a coincident step event; that step is discarded.
- On a step, only the active mode's state advances:
  - Rotate: pos ← pos+1, wrapping NLEDS-1 → 0.
  - Bounce, dir=0: pos<NLEDS-1 → pos+1; pos=NLEDS-1 → pos ← NLEDS-2, dir ← 1.
  - Bounce, dir=1: pos>0 → pos-1; pos=0 → pos ← 1, dir ← 0.
  - Bounce never dwells twice at an end.
  - Binary: bcnt ← bcnt+1, modulo 2^NLEDS.
  - Breathe: bright follows the same bounce rule over 0 … 2^PWM_BITS-1, with bdir as the direction bit.
- Pattern function f(state):
  - Rotate and bounce: 1 << pos.
  - Binary: bcnt.
  - Breathe: all ones if pwm < bright, else 0. bright=0 means always off; maximum brightness is on for 2^PWM_BITS-1 of every 2^PWM_BITS clocks.
- led is registered and equals f() of the state after this edge's update. The implementation computes it from next-state values.

## Timing
- led first shows a valid pattern on the first edge after rst falls (0x01 in rotate mode with NLEDS=8).
- Step cadence with run held high:
  - First step on the 2^LOG2DELAY-th edge after reset release or after a mode change.
  - Then every 2^LOG2DELAY edges.
- tick is high for exactly the one cycle following a step edge. led shows the new pattern in that same cycle, so there is zero latency between tick and the pattern change.
- run=0 mid-period holds presc. After run returns, the step occurs after the remaining count; no count is lost or added.
- run=0 exactly when presc = all-ones: no step, and presc holds at all-ones. The step fires on the first edge with run=1.
- Breathe mode while paused: pwm keeps running, so brightness is held rather than frozen on or off.
- mode_q resets to 0. A nonzero mode at reset release therefore causes one restart on the first edge; this is harmless and expected.
- rst asserted mid-operation clears led and tick immediately. Operation restarts as from power-up.

## Test plan
All scenarios use NLEDS=8, LOG2DELAY=2, PWM_BITS=2.
- Rotate: mode=0, run=1 after reset -> led 0x01, then 0x02, 0x04 … 0x80, 0x01 stepping every 4 clocks. tick pulses once per step, aligned with each led change.
- Bounce: mode=1 -> led 0x01,0x02 … 0x80,0x40 … 0x01,0x02. Period is 14 steps and no end value repeats consecutively.
- Binary: mode=2 -> led counts 0x00,0x01 … 0xFF, then 0x00 after 256 steps.
- Breathe: mode=3 -> bright sequence 0,1,2,3,2,1,0,1. At bright=2, led = 0xFF for exactly 2 of every 4 clocks; at bright=0, led stays 0x00.
- Pause and mode switch:
  - run dropped 1 clock into a period and held for 10 clocks -> no tick, led frozen; the next step comes 3 clocks after run returns.
  - Switching mode 0 → 1 when presc = all-ones -> no tick on that edge, pos restarts at 0, and the first step occurs 4 clocks later.
- Async reset: rst pulsed between clock edges while led=0x10 -> led = 0x00 and tick = 0 before the next edge. After release, led = 0x01 on the first edge.
